// File: rtl/wb_pkg.sv
// Shared definitions for the writeback selector: load size codes, FSM states
// and a select-width helper.
package wb_pkg;

  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_selecter_if.sv
// Writeback request, memory response and register-file write port bundle.
interface wb_selecter_if
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NSRC    = 4,
  parameter int RADDR_W = 5,
  parameter int SEL_W   = sel_width(NSRC)
);

  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       src_sel;
  logic [NSRC*DATA_W-1:0] src_data;
  logic [RADDR_W-1:0]     dest;
  logic                   is_load;
  logic [1:0]             ld_size;
  logic                   ld_signed;
  logic [1:0]             addr_lo;
  logic                   mem_rvalid;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   wr_en;
  logic [RADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   pend_valid;
  logic [RADDR_W-1:0]     pend_dest;

  modport master (
    output in_valid, src_sel, src_data, dest, is_load, ld_size, ld_signed,
           addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, wr_en, wr_addr, wr_data, pend_valid, pend_dest
  );

  modport slave (
    input  in_valid, src_sel, src_data, dest, is_load, ld_size, ld_signed,
           addr_lo, mem_rvalid, mem_rdata,
    output in_ready, wr_en, wr_addr, wr_data, pend_valid, pend_dest
  );

endinterface

// File: rtl/wb_load_align.sv
// Extracts the addressed byte/halfword/word from a little-endian memory word
// and sign- or zero-extends it to the datapath width.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(rdata >> {addr_lo, 3'b000});
    half_v = 16'(rdata >> {addr_lo[1], 4'b0000});
    data   = rdata;
    // Size code 2'b11 is not a real load size and falls through as a word
    case (size)
      LD_B:    data = {{(DATA_W-8){sign_ext & byte_v[7]}}, byte_v};
      LD_H:    data = {{(DATA_W-16){sign_ext & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_selecter.sv
// Writeback stage: forwards a selected source or an aligned load result to the
// register-file write port, stalling new requests while a load is outstanding.
module wb_selecter
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NSRC        = 4,
  parameter int RADDR_W     = 5,
  parameter int ZERO_REG_WR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_selecter_if.slave  bus
);

  localparam int SEL_W = sel_width(NSRC);

  wb_state_t state, next_state;

  logic [SEL_W-1:0]   sel;
  logic [DATA_W-1:0]  src_word;
  logic [DATA_W-1:0]  aligned;
  logic               capture_load;
  logic               do_write;
  logic               write_allowed;
  logic [RADDR_W-1:0] write_addr;
  logic [DATA_W-1:0]  write_data;

  logic [RADDR_W-1:0] ld_dest;
  logic [1:0]         ld_size_q;
  logic [1:0]         addr_lo_q;
  logic               ld_signed_q;

  logic               wr_en_q;
  logic [RADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic               pend_valid_q;

  assign sel = bus.src_sel;

  // Out-of-range selects keep the source-0 default
  always_comb begin
    src_word = bus.src_data[DATA_W-1:0];
    for (int k = 0; k < NSRC; k++) begin
      if (int'(sel) == k) src_word = bus.src_data[k*DATA_W +: DATA_W];
    end
  end

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .rdata    (bus.mem_rdata),
    .size     (ld_size_q),
    .sign_ext (ld_signed_q),
    .addr_lo  (addr_lo_q),
    .data     (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    capture_load = 1'b0;
    do_write     = 1'b0;
    write_addr   = ld_dest;
    write_data   = aligned;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.is_load) begin
            capture_load = 1'b1;
            next_state   = WAIT_MEM;
          end else begin
            do_write   = 1'b1;
            write_addr = bus.dest;
            write_data = src_word;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          do_write   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A suppressed register-0 write still consumes the request but leaves the port untouched
  assign write_allowed = do_write && ((ZERO_REG_WR != 0) || (write_addr != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      pend_valid_q <= 1'b0;
      ld_dest      <= '0;
      ld_size_q    <= LD_W;
      addr_lo_q    <= '0;
      ld_signed_q  <= 1'b0;
    end else begin
      wr_en_q <= write_allowed;
      if (write_allowed) begin
        wr_addr_q <= write_addr;
        wr_data_q <= write_data;
      end
      if (capture_load) begin
        pend_valid_q <= 1'b1;
        ld_dest      <= bus.dest;
        ld_size_q    <= bus.ld_size;
        addr_lo_q    <= bus.addr_lo;
        ld_signed_q  <= bus.ld_signed;
      end else if (state == WAIT_MEM && bus.mem_rvalid) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.pend_valid = pend_valid_q;
  assign bus.pend_dest  = ld_dest;

endmodule

// File: tb/tb_wb_selecter.sv
// Self-checking bench: directed scenarios then random traffic against a
// behavioural writeback model.
module tb_wb_selecter;

  localparam int DATA_W  = 32;
  localparam int NSRC    = 4;
  localparam int RADDR_W = 5;
  localparam int SEL_W   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_selecter_if #(.DATA_W(DATA_W), .NSRC(NSRC), .RADDR_W(RADDR_W)) bus ();
  wb_selecter #(.DATA_W(DATA_W), .NSRC(NSRC), .RADDR_W(RADDR_W), .ZERO_REG_WR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Three-source instance so an out-of-range select is expressible; writes to r0 allowed
  wb_selecter_if #(.DATA_W(DATA_W), .NSRC(3), .RADDR_W(RADDR_W)) bus3 ();
  wb_selecter #(.DATA_W(DATA_W), .NSRC(3), .RADDR_W(RADDR_W), .ZERO_REG_WR(1)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] src  [NSRC];
  logic [31:0] src3 [3];

  bit          m_wait;
  logic [4:0]  m_dest;
  logic [1:0]  m_size, m_alo;
  bit          m_sgn;
  bit          e_wr_en, e_pend_valid;
  logic [4:0]  e_wr_addr, e_pend_dest;
  logic [31:0] e_wr_data;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] refLoad(input logic [31:0] rd, input logic [1:0] sz,
                                          input bit sg, input logic [1:0] al);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (al * 8)) & 32'hFF;
      if (sg && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> ((al / 2) * 16)) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] refSource(input logic [SEL_W-1:0] s);
    return (int'(s) >= NSRC) ? src[0] : src[s];
  endfunction

  task automatic modelReset();
    m_wait = 0; e_wr_en = 0; e_pend_valid = 0;
    e_wr_addr = '0; e_wr_data = '0; e_pend_dest = '0;
  endtask

  task automatic driveIdle();
    bus.in_valid = 0; bus.src_sel = '0; bus.dest = '0; bus.is_load = 0;
    bus.ld_size = '0; bus.ld_signed = 0; bus.addr_lo = '0;
    bus.mem_rvalid = 0; bus.mem_rdata = '0;
    for (int k = 0; k < NSRC; k++) bus.src_data[k*DATA_W +: DATA_W] = src[k];
    bus3.in_valid = 0; bus3.src_sel = '0; bus3.dest = '0; bus3.is_load = 0;
    bus3.ld_size = '0; bus3.ld_signed = 0; bus3.addr_lo = '0;
    bus3.mem_rvalid = 0; bus3.mem_rdata = '0; bus3.src_data = '0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".wr_en"}, 32'(bus.wr_en), 32'(e_wr_en));
    checkOutput({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(e_wr_addr));
    checkOutput({tag, ".wr_data"}, bus.wr_data, e_wr_data);
    checkOutput({tag, ".pend_valid"}, 32'(bus.pend_valid), 32'(e_pend_valid));
    if (e_pend_valid) checkOutput({tag, ".pend_dest"}, 32'(bus.pend_dest), 32'(e_pend_dest));
  endtask

  // One clock of traffic: drive at a falling edge, predict the rising edge, check at the next falling edge
  task automatic applyStimulus(input string tag, input bit v, input logic [SEL_W-1:0] sel,
                               input logic [4:0] d, input bit ld, input logic [1:0] sz,
                               input bit sg, input logic [1:0] al, input bit rv,
                               input logic [31:0] rd);
    checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!m_wait));
    for (int k = 0; k < NSRC; k++) bus.src_data[k*DATA_W +: DATA_W] = src[k];
    bus.in_valid = v; bus.src_sel = sel; bus.dest = d; bus.is_load = ld;
    bus.ld_size = sz; bus.ld_signed = sg; bus.addr_lo = al;
    bus.mem_rvalid = rv; bus.mem_rdata = rd;
    e_wr_en = 0;
    if (!m_wait) begin
      if (v && !ld) begin
        if (d != 0) begin
          e_wr_en = 1; e_wr_addr = d; e_wr_data = refSource(sel);
        end
      end else if (v && ld) begin
        m_wait = 1; m_dest = d; m_size = sz; m_sgn = sg; m_alo = al;
        e_pend_valid = 1; e_pend_dest = d;
      end
    end else if (rv) begin
      m_wait = 0; e_pend_valid = 0;
      if (m_dest != 0) begin
        e_wr_en = 1; e_wr_addr = m_dest; e_wr_data = refLoad(rd, m_size, m_sgn, m_alo);
      end
    end
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    driveIdle();
    #1;
    modelReset();
    checkAll(tag);
    checkOutput({tag, ".pend_dest"}, 32'(bus.pend_dest), 32'd0);
    checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 0, '0, '0, 0, 2'd0, 0, 2'd0, 0, 32'h0);
  endtask

  initial begin
    for (int k = 0; k < NSRC; k++) src[k] = 32'h1000_0000 * (k + 1);
    driveIdle();
    #2;
    doReset("reset");

    src[2] = 32'h0000_1234;
    applyStimulus("alu_sel2", 1, 2'd2, 5'd3, 0, 2'd0, 0, 2'd0, 0, 32'h0);
    checkOutput("alu_sel2.data_const", bus.wr_data, 32'h0000_1234);
    idleCycle("alu_pulse_end");

    applyStimulus("lb_accept", 1, 2'd0, 5'd5, 1, 2'd0, 1, 2'd2, 0, 32'h0);
    idleCycle("lb_wait1");
    idleCycle("lb_wait2");
    applyStimulus("lb_resp", 0, 2'd0, 5'd0, 0, 2'd0, 0, 2'd0, 1, 32'h1180_7F22);
    checkOutput("lb_resp.data_const", bus.wr_data, 32'hFFFF_FF80);
    idleCycle("lb_after");

    applyStimulus("lh_accept", 1, 2'd0, 5'd6, 1, 2'd1, 0, 2'd3, 0, 32'h0);
    applyStimulus("lh_blocked", 1, 2'd1, 5'd7, 0, 2'd0, 0, 2'd0, 0, 32'h0);
    applyStimulus("lh_resp", 0, 2'd0, 5'd0, 0, 2'd0, 0, 2'd0, 1, 32'hABCD_0001);
    checkOutput("lh_resp.data_const", bus.wr_data, 32'h0000_ABCD);
    idleCycle("lh_after");

    for (int i = 1; i <= 4; i++) begin
      for (int k = 0; k < NSRC; k++) src[k] = $urandom;
      applyStimulus("b2b", 1, SEL_W'($urandom_range(0, 3)), 5'(i), 0, 2'd0, 0, 2'd0, 0, 32'h0);
      checkOutput("b2b.addr_const", 32'(bus.wr_addr), i);
    end
    idleCycle("b2b_after");

    applyStimulus("rst_ld_accept", 1, 2'd0, 5'd9, 1, 2'd2, 0, 2'd0, 0, 32'h0);
    idleCycle("rst_ld_wait");
    #2;
    doReset("rst_mid_load");
    applyStimulus("rst_late_rvalid", 0, 2'd0, 5'd0, 0, 2'd0, 0, 2'd0, 1, 32'hDEAD_BEEF);

    src[0] = 32'h0BAD_F00D;
    applyStimulus("dest0", 1, 2'd0, 5'd0, 0, 2'd0, 0, 2'd0, 0, 32'h0);
    applyStimulus("idle_rvalid", 0, 2'd0, 5'd0, 0, 2'd0, 0, 2'd0, 1, 32'h5555_5555);

    for (int k = 0; k < 3; k++) src3[k] = $urandom;
    bus3.src_data = {src3[2], src3[1], src3[0]};
    bus3.in_valid = 1; bus3.src_sel = 2'd3; bus3.dest = 5'd0; bus3.is_load = 0;
    idleCycle("n3_sel3");
    checkOutput("n3_sel3.wr_en", 32'(bus3.wr_en), 32'd1);
    checkOutput("n3_sel3.wr_addr", 32'(bus3.wr_addr), 32'd0);
    checkOutput("n3_sel3.wr_data", bus3.wr_data, src3[0]);
    bus3.src_sel = 2'd1; bus3.dest = 5'd2;
    idleCycle("n3_sel1");
    checkOutput("n3_sel1.wr_addr", 32'(bus3.wr_addr), 32'd2);
    checkOutput("n3_sel1.wr_data", bus3.wr_data, src3[1]);
    bus3.in_valid = 0;

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NSRC; k++) src[k] = $urandom;
      applyStimulus("rand", $urandom_range(0, 3) != 0, SEL_W'($urandom),
                    5'($urandom), $urandom_range(0, 2) == 0, 2'($urandom), 1'($urandom),
                    2'($urandom), $urandom_range(0, 2) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
